// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: mid-bit sampling UART receiver with a valid/ready output
// and parity, framing and overrun status per word.
module uart_rx_oversampled #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 ready,
    output logic                 valid,
    output logic [DATA_BITS-1:0] result,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t               r_state;
    logic [1:0]           r_sync;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bits;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_perr, r_ferr, r_armed;
    logic                 w_rx_s, w_mid, w_ferr, w_pub, w_last_data;
    assign w_rx_s      = r_sync[1];
    assign w_mid       = r_cnt == ((r_state == START) ? CW'(CLKS_PER_BIT/2-1) : CW'(CLKS_PER_BIT-1));
    assign w_ferr      = r_ferr | ~w_rx_s;
    assign w_pub       = (r_state == STOP) && w_mid && (r_bits == 4'(STOP_BITS-1));
    assign w_last_data = r_bits == 4'(DATA_BITS-1);
    assign busy        = r_state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sync     <= 2'b11;
            r_cnt      <= '0;
            r_bits     <= '0;
            r_data     <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_armed    <= 1'b0;
            valid      <= 1'b0;
            result     <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_cnt   <= (r_state == IDLE || w_mid) ? '0 : r_cnt + 1'b1;
            // a framing error disarms so a held-low line yields a single word
            r_armed <= w_rx_s | (r_armed & ~(w_pub & w_ferr));
            if (w_pub) begin
                valid      <= 1'b1;
                result     <= r_data;
                parity_err <= r_perr;
                frame_err  <= w_ferr;
                overrun    <= valid & ~ready;
            end else if (valid & ready) begin
                valid      <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end
            case (r_state)
                IDLE: if (!w_rx_s && r_armed) begin
                    r_state <= START;
                    r_bits  <= '0;
                    r_perr  <= 1'b0;
                    r_ferr  <= 1'b0;
                end
                START: if (w_mid) r_state <= w_rx_s ? IDLE : DATA;
                DATA: if (w_mid) begin
                    r_data  <= {w_rx_s, r_data[DATA_BITS-1:1]};
                    r_bits  <= w_last_data ? '0 : r_bits + 1'b1;
                    r_state <= !w_last_data ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: if (w_mid) begin
                    r_perr  <= ((^r_data) ^ w_rx_s) != 1'(PARITY_ODD);
                    r_state <= STOP;
                end
                STOP: if (w_mid) begin
                    r_ferr  <= w_ferr;
                    r_bits  <= r_bits + 1'b1;
                    r_state <= w_pub ? IDLE : STOP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
